rr_arb_requester: RTL and testbench
===================================

# rr_arb_requester

Client-side controller for the 4-way round-robin request/grant interface. It holds a pending-beat count per channel and drives `request[3:0]` toward the arbiter. Each cycle it is granted, it consumes one beat and emits a registered beat strobe. It also checks the arbiter's behaviour: spurious grants, multi-hot grants and starvation.

## Interface
Parameters:
- `CNT_W`, default 4: width of each channel's pending-beat counter; max pending = 2^CNT_W-1.
- `STARVE_LIMIT`, default 8: consecutive request-without-grant cycles that flag starvation.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `push_valid`, in, 1: push of new work.
- `push_ch`, in, 2: target channel of the push.
- `push_len`, in, `CNT_W`: beats to add.
- `push_ready`, out, 1: push accepted this cycle (combinational).
- `grant`, in, 4: grant from arbiter; expected one-hot or zero.
- `request`, out, 4: request to arbiter (combinational from state, `grant` and push).
- `beat_valid`, out, 1: registered; one beat served.
- `beat_ch`, out, 2: registered; channel of the served beat.
- `beat_last`, out, 1: registered; the served beat emptied the channel.
- `pending_o`, out, 4×`CNT_W`: current per-channel counts (for debug).
- `spurious_err`, out, 1: sticky.
- `multi_err`, out, 1: sticky.
- `starve`, out, 4: sticky, per channel.

## Operation
- Per-channel state, derived from `pend[i]` and the `served[i]` bit:
  - IDLE: `pend == 0`.
  - WAIT: `pend > 0`, not yet granted in the current job.
  - SERVE: `pend > 0`, granted at least once.
  - Transitions: IDLE→WAIT on accepted push with `len > 0`. WAIT→SERVE on first valid grant. SERVE/WAIT→IDLE when the last beat is consumed and there is no same-cycle push.
- Push acceptance:
  - `push_ready = !push_valid || (pend[push_ch] + push_len <= 2^CNT_W-1)`.
  - The sum is computed at `CNT_W+1` bits.
  - When `grant[push_ch]` is valid in the same cycle, the check uses `pend - 1`.
  - `push_len == 0` is accepted as a no-op.
- A grant is valid when `grant` is one-hot, `pend[i] > 0`, and no error is detected this cycle.
- Counter update: `pend_next = pend + (accepted push ? len : 0) - (valid grant ? 1 : 0)`.
- `request[i] = (pend[i] != 0) && !(valid grant[i] && pend[i] == 1 && !(accepted push to i with len > 0))`.
  - The request drops in the cycle of the final grant, so the arbiter's registered next state never re-grants an empty channel.
- Error handling:
  - Multi-hot grant: set `multi_err`, consume nothing, no beat.
  - Grant to a channel with `pend == 0`: set `spurious_err`, no beat.
- Starvation:
  - `wait_cnt[i]` increments while `request[i] && !grant[i]`, clears otherwise.
  - It saturates at `STARVE_LIMIT`; reaching it sets `starve[i]`.

## Timing
- Reset values:
  - All `pend`, `served`, `wait_cnt` = 0.
  - `beat_valid`, `beat_ch`, `beat_last` = 0.
  - `spurious_err`, `multi_err`, `starve` = 0.
  - `request` = 0.
- Push accepted at edge t → `request[i]` high from t+1. With an idle arbiter, `grant[i]` arrives in the cycle after edge t+2, and `beat_valid` in the cycle after edge t+3.
- `beat_valid`/`beat_ch`/`beat_last` are registered copies of the valid-grant decision: one cycle latency, one beat per cycle maximum.
- Push and grant on the same channel in one cycle are both applied (net `+len-1`).
- Reset mid-job discards all pending beats immediately. The sticky flags clear only on reset.

## Structure
- The shared package holds:
  - The channel count constant (4) and the channel index type.
  - The per-channel state enum (IDLE/WAIT/SERVE), shared with the arbiter bench.
- One sub-module is natural: `rr_req_channel`, instantiated 4×. It holds the counter, the served bit, the starvation counter and the local request term. The top level holds push decode, one-hot/error checks and the beat register.

## Test plan
- Reset: assert `rst` with pushes pending → all outputs 0; after release, `request == 0`.
- Single channel: push ch1 `len=3` → `grant[1]` in 3 consecutive cycles; `beat_ch=1` ×3 with `beat_last` on the third; `request[1]` low in the third grant cycle; no `spurious_err`.
- Rotation: push ch0..ch3 `len=2` each → beats in channel order 0,1,2,3,0,1,2,3; `starve == 0`.
- Overflow: `pend[2]=14` (`CNT_W=4`), push `len=2` → `push_ready=0`, count stays 14. Push `len=1` → accepted, count 15.
- Errors: drive `grant=4'b0101` → `multi_err=1`, no beat. Drive `grant=4'b1000` with `pend[3]=0` → `spurious_err=1`. A held-off grant to a requesting channel for 8 cycles → `starve` bit set.
- Same-cycle push and final grant on ch0 (`pend=1`, push `len=2`) → `pend` becomes 2, `request[0]` stays high, `beat_last=0`.

Source files
------------

// File: rtl/rr_arb_requester_pkg.sv
// Shared types for the round-robin requester and its arbiter bench.
// Channel count, channel index and per-channel job state.
package rr_arb_requester_pkg;

    localparam int NCH = 4;

    typedef logic [1:0] ch_idx_t;

    typedef enum logic [1:0] {
        CH_IDLE,
        CH_WAIT,
        CH_SERVE
    } ch_state_t;

    function automatic logic is_onehot(input logic [NCH-1:0] v);
        return $countones(v) == 1;
    endfunction

    function automatic ch_idx_t onehot_idx(input logic [NCH-1:0] v);
        ch_idx_t idx;
        idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (v[i]) idx = ch_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arb_requester_channel.sv
// One requester channel: pending-beat counter, served bit,
// starvation watchdog and the local request term.
module rr_req_channel
    import rr_arb_requester_pkg::*;
#(
    parameter int CNT_W        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_en,
    input  logic [CNT_W-1:0] push_len,
    input  logic             gnt_ok,
    input  logic             gnt_raw,
    output logic [CNT_W-1:0] pend,
    output logic             req,
    output logic             drain,
    output logic             starve
);

    localparam int WW = $clog2(STARVE_LIMIT + 1);
    localparam logic [WW-1:0]    LIM  = WW'(STARVE_LIMIT);
    localparam logic [WW-1:0]    WONE = WW'(1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] pend_q, pend_d;
    logic             served_q, served_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic             starve_q, starve_d;
    ch_state_t        state;

    always_comb begin
        state = CH_IDLE;
        if (pend_q != '0) state = served_q ? CH_SERVE : CH_WAIT;
    end

    // A same-cycle push with beats keeps the job alive through the final grant.
    assign drain = gnt_ok && (pend_q == ONE)
                 && !(push_en && (push_len != '0));
    assign req   = (state != CH_IDLE) && !drain;

    always_comb begin
        pend_d = pend_q;
        if (push_en) pend_d = pend_d + push_len;
        if (gnt_ok)  pend_d = pend_d - ONE;

        served_d = served_q;
        if (gnt_ok)         served_d = 1'b1;
        if (pend_d == '0)   served_d = 1'b0;

        wait_d = '0;
        if (req && !gnt_raw) begin
            wait_d = (wait_q == LIM) ? wait_q : wait_q + WONE;
        end
        starve_d = starve_q | (wait_d == LIM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q   <= '0;
            served_q <= 1'b0;
            wait_q   <= '0;
            starve_q <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            served_q <= served_d;
            wait_q   <= wait_d;
            starve_q <= starve_d;
        end
    end

    assign pend   = pend_q;
    assign starve = starve_q;

endmodule

// File: rtl/rr_arb_requester.sv
// Client side of the 4-way round-robin interface: queues beats per
// channel, requests them, and polices the arbiter's grants.
module rr_arb_requester
    import rr_arb_requester_pkg::*;
#(
    parameter int CNT_W        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_valid,
    input  logic [1:0]           push_ch,
    input  logic [CNT_W-1:0]     push_len,
    output logic                 push_ready,
    input  logic [NCH-1:0]       grant,
    output logic [NCH-1:0]       request,
    output logic                 beat_valid,
    output logic [1:0]           beat_ch,
    output logic                 beat_last,
    output logic [NCH*CNT_W-1:0] pending_o,
    output logic                 spurious_err,
    output logic                 multi_err,
    output logic [NCH-1:0]       starve
);

    localparam logic [CNT_W:0]   MAXV = {1'b0, {CNT_W{1'b1}}};
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] pend [NCH];
    logic [NCH-1:0]   nonempty;
    logic [NCH-1:0]   gnt_ok;
    logic [NCH-1:0]   push_hit;
    logic [NCH-1:0]   drain;
    logic             multi;
    logic             spur;
    logic             push_acc;
    logic [CNT_W-1:0] eff_pend;
    logic [CNT_W:0]   sum;

    assign multi  = (grant != '0) && !is_onehot(grant);
    assign spur   = |(grant & ~nonempty);
    assign gnt_ok = (is_onehot(grant) && !spur) ? grant : '0;

    // Room check sees the beat being consumed this cycle.
    always_comb begin
        eff_pend = pend[push_ch];
        if (gnt_ok[push_ch]) eff_pend = eff_pend - ONE;
        sum = {1'b0, eff_pend} + {1'b0, push_len};
    end

    assign push_ready = !push_valid || (sum <= MAXV);
    assign push_acc   = push_valid && push_ready;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign push_hit[i] = push_acc && (push_ch == ch_idx_t'(i));
        assign nonempty[i] = pend[i] != '0;
        assign pending_o[i*CNT_W +: CNT_W] = pend[i];

        rr_req_channel #(
            .CNT_W        (CNT_W),
            .STARVE_LIMIT (STARVE_LIMIT)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .push_en  (push_hit[i]),
            .push_len (push_len),
            .gnt_ok   (gnt_ok[i]),
            .gnt_raw  (grant[i]),
            .pend     (pend[i]),
            .req      (request[i]),
            .drain    (drain[i]),
            .starve   (starve[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_valid   <= 1'b0;
            beat_ch      <= '0;
            beat_last    <= 1'b0;
            multi_err    <= 1'b0;
            spurious_err <= 1'b0;
        end else begin
            beat_valid   <= |gnt_ok;
            beat_ch      <= onehot_idx(gnt_ok);
            beat_last    <= |drain;
            multi_err    <= multi_err | multi;
            spurious_err <= spurious_err | spur;
        end
    end

endmodule

// File: tb/tb_rr_arb_requester.sv
// Directed bench for rr_arb_requester; the bench plays the arbiter.
// Inputs change on the falling edge, outputs are sampled 1ns later.
module tb_rr_arb_requester;

    logic        clk = 1'b0;
    logic        rst;
    logic        push_valid;
    logic [1:0]  push_ch;
    logic [3:0]  push_len;
    logic        push_ready;
    logic [3:0]  grant;
    logic [3:0]  request;
    logic        beat_valid;
    logic [1:0]  beat_ch;
    logic        beat_last;
    logic [15:0] pending_o;
    logic        spurious_err;
    logic        multi_err;
    logic [3:0]  starve;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        pv;
        logic [1:0]  ch;
        logic [3:0]  len;
        logic [3:0]  gnt;
        logic        rdy;
        logic [3:0]  req;
        logic        bv;
        logic [1:0]  bch;
        logic        bl;
        logic [15:0] pend;
    } vec_t;

    vec_t tbl[$];

    rr_arb_requester #(
        .CNT_W        (4),
        .STARVE_LIMIT (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .push_valid   (push_valid),
        .push_ch      (push_ch),
        .push_len     (push_len),
        .push_ready   (push_ready),
        .grant        (grant),
        .request      (request),
        .beat_valid   (beat_valid),
        .beat_ch      (beat_ch),
        .beat_last    (beat_last),
        .pending_o    (pending_o),
        .spurious_err (spurious_err),
        .multi_err    (multi_err),
        .starve       (starve)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic pv, input logic [1:0] ch,
                       input logic [3:0] len, input logic [3:0] gnt,
                       input logic rdy, input logic [3:0] req,
                       input logic bv, input logic [1:0] bch,
                       input logic bl, input logic [15:0] pend);
        vec_t v;
        v.pv = pv; v.ch = ch; v.len = len; v.gnt = gnt;
        v.rdy = rdy; v.req = req; v.bv = bv; v.bch = bch;
        v.bl = bl; v.pend = pend;
        tbl.push_back(v);
    endtask

    task automatic cyc(input logic pv, input logic [1:0] ch,
                       input logic [3:0] len, input logic [3:0] gnt);
        @(negedge clk);
        push_valid = pv;
        push_ch    = ch;
        push_len   = len;
        grant      = gnt;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        push_valid = 1'b0; push_ch = '0; push_len = '0; grant = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        push_valid = 1'b0; push_ch = '0; push_len = '0; grant = '0;

        // single channel, len 3
        add(1'b1, 2'd1, 4'd3, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 16'h0000);
        add(1'b0, 2'd0, 4'd0, 4'b0000, 1'b1, 4'b0010, 1'b0, 2'd0, 1'b0, 16'h0030);
        add(1'b0, 2'd0, 4'd0, 4'b0000, 1'b1, 4'b0010, 1'b0, 2'd0, 1'b0, 16'h0030);
        add(1'b0, 2'd0, 4'd0, 4'b0010, 1'b1, 4'b0010, 1'b0, 2'd0, 1'b0, 16'h0030);
        add(1'b0, 2'd0, 4'd0, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b0, 16'h0020);
        add(1'b0, 2'd0, 4'd0, 4'b0010, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b0, 16'h0010);
        add(1'b0, 2'd0, 4'd0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b1, 16'h0000);
        add(1'b0, 2'd0, 4'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 16'h0000);
        // rotation, len 2 on every channel
        add(1'b1, 2'd0, 4'd2, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 16'h0000);
        add(1'b1, 2'd1, 4'd2, 4'b0000, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0, 16'h0002);
        add(1'b1, 2'd2, 4'd2, 4'b0000, 1'b1, 4'b0011, 1'b0, 2'd0, 1'b0, 16'h0022);
        add(1'b1, 2'd3, 4'd2, 4'b0001, 1'b1, 4'b0111, 1'b0, 2'd0, 1'b0, 16'h0222);
        add(1'b0, 2'd0, 4'd0, 4'b0010, 1'b1, 4'b1111, 1'b1, 2'd0, 1'b0, 16'h2221);
        add(1'b0, 2'd0, 4'd0, 4'b0100, 1'b1, 4'b1111, 1'b1, 2'd1, 1'b0, 16'h2211);
        add(1'b0, 2'd0, 4'd0, 4'b1000, 1'b1, 4'b1111, 1'b1, 2'd2, 1'b0, 16'h2111);
        add(1'b0, 2'd0, 4'd0, 4'b0001, 1'b1, 4'b1110, 1'b1, 2'd3, 1'b0, 16'h1111);
        add(1'b0, 2'd0, 4'd0, 4'b0010, 1'b1, 4'b1100, 1'b1, 2'd0, 1'b1, 16'h1110);
        add(1'b0, 2'd0, 4'd0, 4'b0100, 1'b1, 4'b1000, 1'b1, 2'd1, 1'b1, 16'h1100);
        add(1'b0, 2'd0, 4'd0, 4'b1000, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b1, 16'h1000);
        add(1'b0, 2'd0, 4'd0, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b1, 16'h0000);
        add(1'b0, 2'd0, 4'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 16'h0000);
        // overflow boundary on ch2, then push alongside a grant
        add(1'b1, 2'd2, 4'd14, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 16'h0000);
        add(1'b1, 2'd2, 4'd2, 4'b0000, 1'b0, 4'b0100, 1'b0, 2'd0, 1'b0, 16'h0e00);
        add(1'b1, 2'd2, 4'd1, 4'b0000, 1'b1, 4'b0100, 1'b0, 2'd0, 1'b0, 16'h0e00);
        add(1'b1, 2'd2, 4'd1, 4'b0100, 1'b1, 4'b0100, 1'b0, 2'd0, 1'b0, 16'h0f00);
        add(1'b0, 2'd0, 4'd0, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0, 16'h0f00);
        // zero-length push is a no-op
        add(1'b1, 2'd0, 4'd0, 4'b0000, 1'b1, 4'b0100, 1'b0, 2'd0, 1'b0, 16'h0f00);
        add(1'b0, 2'd0, 4'd0, 4'b0000, 1'b1, 4'b0100, 1'b0, 2'd0, 1'b0, 16'h0f00);

        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            cyc(tbl[i].pv, tbl[i].ch, tbl[i].len, tbl[i].gnt);
            chk($sformatf("row%0d ready", i), 32'(push_ready), 32'(tbl[i].rdy));
            chk($sformatf("row%0d request", i), 32'(request), 32'(tbl[i].req));
            chk($sformatf("row%0d beat_valid", i), 32'(beat_valid), 32'(tbl[i].bv));
            if (tbl[i].bv) begin
                chk($sformatf("row%0d beat_ch", i), 32'(beat_ch), 32'(tbl[i].bch));
                chk($sformatf("row%0d beat_last", i), 32'(beat_last), 32'(tbl[i].bl));
            end
            chk($sformatf("row%0d pending", i), 32'(pending_o), 32'(tbl[i].pend));
        end
        chk("no_starve_yet", 32'(starve), 32'h0);

        // ch2 keeps requesting with no grant; limit is reached on the 8th cycle
        repeat (5) @(negedge clk);
        #1;
        chk("starve_before_limit", 32'(starve), 32'h0);
        @(negedge clk);
        #1;
        chk("starve_at_limit", 32'(starve), 32'h4);
        chk("no_spurious", 32'(spurious_err), 32'h0);
        chk("no_multi", 32'(multi_err), 32'h0);

        // asynchronous reset with work pending and a push offered
        @(negedge clk);
        rst = 1'b1;
        push_valid = 1'b1; push_ch = 2'd0; push_len = 4'd3; grant = '0;
        #1;
        chk("rst pending", 32'(pending_o), 32'h0);
        chk("rst request", 32'(request), 32'h0);
        chk("rst starve", 32'(starve), 32'h0);
        chk("rst beat", 32'({beat_valid, beat_ch, beat_last}), 32'h0);
        chk("rst errs", 32'({spurious_err, multi_err}), 32'h0);
        @(negedge clk);
        #1;
        chk("rst hold pending", 32'(pending_o), 32'h0);
        rst = 1'b0;
        push_valid = 1'b0;
        cyc(1'b0, 2'd0, 4'd0, 4'b0000);
        chk("post_rst request", 32'(request), 32'h0);

        // multi-hot grant with both channels pending
        cyc(1'b1, 2'd0, 4'd1, 4'b0000);
        cyc(1'b1, 2'd2, 4'd1, 4'b0000);
        cyc(1'b0, 2'd0, 4'd0, 4'b0101);
        chk("multi request", 32'(request), 32'h5);
        cyc(1'b0, 2'd0, 4'd0, 4'b0000);
        chk("multi_err", 32'(multi_err), 32'h1);
        chk("multi no_spur", 32'(spurious_err), 32'h0);
        chk("multi no_beat", 32'(beat_valid), 32'h0);
        chk("multi pending", 32'(pending_o), 32'h0101);

        // grant to an empty channel
        do_reset();
        cyc(1'b0, 2'd0, 4'd0, 4'b1000);
        cyc(1'b0, 2'd0, 4'd0, 4'b0000);
        chk("spurious_err", 32'(spurious_err), 32'h1);
        chk("spur no_multi", 32'(multi_err), 32'h0);
        chk("spur no_beat", 32'(beat_valid), 32'h0);

        // final grant on ch0 together with a fresh push
        do_reset();
        cyc(1'b1, 2'd0, 4'd1, 4'b0000);
        cyc(1'b1, 2'd0, 4'd2, 4'b0001);
        chk("same ready", 32'(push_ready), 32'h1);
        chk("same request", 32'(request), 32'h1);
        cyc(1'b0, 2'd0, 4'd0, 4'b0000);
        chk("same pending", 32'(pending_o), 32'h2);
        chk("same beat_valid", 32'(beat_valid), 32'h1);
        chk("same beat_ch", 32'(beat_ch), 32'h0);
        chk("same beat_last", 32'(beat_last), 32'h0);
        chk("same request_after", 32'(request), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
